// File: rtl/motor_drive_stage.sv
// motor_drive_stage: power stage for the EV motor controller. Slew-limits the
// speed command into an applied duty, latches that duty at PWM period
// boundaries, drives complementary gates with dead time, and holds an
// emergency-stop latch that needs enable dropped before it re-arms.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   enable            drive enable
//   speed_cmd[7:0]    requested duty
//   overheat          thermal fault, halves the target
//   estop             emergency stop, level-sensitive
//   pwm_hi, pwm_lo    high-side / low-side gate drives (never both high)
//   duty[7:0]         current ramped duty
//   state[1:0]        OFF=0, RAMP=1, RUN=2, STOP=3
//   at_speed          high while in RUN
//   period_tick       one-cycle pulse on the last count of each PWM period
module motor_drive_stage #(
   parameter int unsigned RAMP_DIV  = 16,
   parameter int unsigned RAMP_STEP = 1,
   parameter int unsigned DEAD_CYC  = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic [7:0] speed_cmd,
   input  logic       overheat,
   input  logic       estop,
   output logic       pwm_hi,
   output logic       pwm_lo,
   output logic [7:0] duty,
   output logic [1:0] state,
   output logic       at_speed,
   output logic       period_tick
);

   localparam int unsigned DW  = 8;
   localparam int unsigned DW1 = DW + 1;
   localparam int unsigned PW  = 8;
   localparam int unsigned CW  = 4;
   localparam logic [DW-1:0] CNT_LAST  = DW'(254);
   localparam logic [PW-1:0] PRE_LAST  = PW'(RAMP_DIV - 1);
   localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYC - 1);
   localparam logic [DW:0]   STEP_W    = DW1'(RAMP_STEP);

   typedef enum logic [1:0] {
      S_OFF  = 2'd0,
      S_RAMP = 2'd1,
      S_RUN  = 2'd2,
      S_STOP = 2'd3
   } state_t;

   state_t        st_q, st_nxt;
   logic [DW-1:0] target, duty_q, duty_nxt, active_q, cnt_q, cnt_nxt;
   logic [DW:0]   up_sum, dn_lim;
   logic [PW-1:0] pre_q;
   logic [CW-1:0] dead_q;
   logic          ramp_tick, clr, raw, raw_q, settled, gate_en;

   assign duty  = duty_q;
   assign state = st_q;

   // Speed target after enable / estop / thermal derating
   always_comb begin
      target = speed_cmd;
      if (estop || !enable) target = '0;
      else if (overheat)    target = speed_cmd >> 1;
   end

   assign ramp_tick = (pre_q == PRE_LAST);

   // Slew limiter; 9-bit sums keep the clamp free of wrap and underflow
   always_comb begin
      up_sum   = {1'b0, duty_q} + STEP_W;
      dn_lim   = {1'b0, target} + STEP_W;
      duty_nxt = duty_q;
      if (clr) begin
         duty_nxt = '0;
      end else if (ramp_tick) begin
         if (duty_q < target)
            duty_nxt = (up_sum >= {1'b0, target}) ? target : up_sum[DW-1:0];
         else if (duty_q > target)
            duty_nxt = (dn_lim >= {1'b0, duty_q}) ? target : duty_q - DW'(RAMP_STEP);
      end
   end

   // PWM period counter 0..254
   always_comb begin
      cnt_nxt = cnt_q + DW'(1);
      if (clr || cnt_q == CNT_LAST) cnt_nxt = '0;
   end

   assign raw     = (cnt_q < active_q);
   // Gate follows raw only once raw has been stable for DEAD_CYC cycles
   assign settled = (raw == raw_q) && (dead_q == DEAD_LAST);

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) st_q <= S_OFF;
      else     st_q <= st_nxt;
   end

   // FSM next state; judged on the post-tick duty so transitions share its edge
   always_comb begin
      st_nxt = st_q;
      if (estop) begin
         st_nxt = S_STOP;
      end else begin
         case (st_q)
            S_STOP: if (!enable) st_nxt = S_OFF;
            S_OFF:  if (target != '0) st_nxt = S_RAMP;
            S_RAMP: if (duty_nxt == target) st_nxt = (target == '0) ? S_OFF : S_RUN;
            S_RUN:  if (duty_nxt != target) st_nxt = S_RAMP;
            default: st_nxt = S_OFF;
         endcase
      end
   end

   // FSM outputs: gate enable and the stop-latch clear
   always_comb begin
      gate_en = 1'b0;
      clr     = estop || (st_q == S_STOP);
      if (st_nxt == S_RAMP || st_nxt == S_RUN) gate_en = 1'b1;
   end

   // Datapath and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         duty_q      <= '0;
         active_q    <= '0;
         cnt_q       <= '0;
         pre_q       <= '0;
         raw_q       <= 1'b0;
         dead_q      <= '0;
         pwm_hi      <= 1'b0;
         pwm_lo      <= 1'b0;
         at_speed    <= 1'b0;
         period_tick <= 1'b0;
      end else begin
         duty_q      <= duty_nxt;
         cnt_q       <= cnt_nxt;
         period_tick <= (cnt_nxt == CNT_LAST);
         at_speed    <= (st_nxt == S_RUN);
         pwm_hi      <= gate_en && settled && raw;
         pwm_lo      <= gate_en && settled && !raw;
         if (clr) begin
            pre_q    <= '0;
            active_q <= '0;
            raw_q    <= 1'b0;
            dead_q   <= '0;
         end else begin
            pre_q <= ramp_tick ? '0 : pre_q + PW'(1);
            if (cnt_q == CNT_LAST) active_q <= duty_q;
            raw_q <= raw;
            if (raw != raw_q)             dead_q <= '0;
            else if (dead_q != DEAD_LAST) dead_q <= dead_q + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_motor_drive_stage.sv
// Bench for motor_drive_stage: instance A uses default parameters, instance B
// uses a coarse step (RAMP_DIV=2, RAMP_STEP=100). Expected duty values are
// queued as stimulus is applied and compared whenever the DUT duty changes.
module tb_motor_drive_stage;

   localparam logic [31:0] OFF = 32'd0, RAMP = 32'd1, RUN = 32'd2, STOP = 32'd3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       en_a, oh_a, es_a, en_b, oh_b, es_b;
   logic [7:0] cmd_a, cmd_b;
   logic       hi_a, lo_a, at_a, tk_a, hi_b, lo_b, at_b, tk_b;
   logic [7:0] duty_a, duty_b;
   logic [1:0] state_a, state_b;

   motor_drive_stage dut_a (
      .clk(clk), .rst(rst), .enable(en_a), .speed_cmd(cmd_a), .overheat(oh_a),
      .estop(es_a), .pwm_hi(hi_a), .pwm_lo(lo_a), .duty(duty_a), .state(state_a),
      .at_speed(at_a), .period_tick(tk_a)
   );

   motor_drive_stage #(.RAMP_DIV(2), .RAMP_STEP(100), .DEAD_CYC(4)) dut_b (
      .clk(clk), .rst(rst), .enable(en_b), .speed_cmd(cmd_b), .overheat(oh_b),
      .estop(es_b), .pwm_hi(hi_b), .pwm_lo(lo_b), .duty(duty_b), .state(state_b),
      .at_speed(at_b), .period_tick(tk_b)
   );

   int checks = 0;
   int errors = 0;
   int overlaps = 0;
   bit mon_en = 1'b0;
   logic [7:0] exp_a[$];
   logic [7:0] exp_b[$];
   logic [7:0] prev_a, prev_b;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Scoreboard: every duty change must match the next queued value
   always @(negedge clk) begin
      if ((hi_a === 1'b1 && lo_a === 1'b1) || (hi_b === 1'b1 && lo_b === 1'b1)) overlaps++;
      if (!mon_en) begin
         prev_a = duty_a;
         prev_b = duty_b;
      end else begin
         if (duty_a !== prev_a) begin
            if (exp_a.size() == 0) begin
               checks++;
               errors++;
               $error("FAIL a_duty_extra observed=%0d expected=none", duty_a);
            end else begin
               chk("a_duty_seq", 32'(duty_a), 32'(exp_a.pop_front()));
            end
         end
         if (duty_b !== prev_b) begin
            if (exp_b.size() == 0) begin
               checks++;
               errors++;
               $error("FAIL b_duty_extra observed=%0d expected=none", duty_b);
            end else begin
               chk("b_duty_seq", 32'(duty_b), 32'(exp_b.pop_front()));
            end
         end
         prev_a = duty_a;
         prev_b = duty_b;
      end
   end

   task automatic wait_state(input bit sel, input logic [31:0] s, input int lim,
                             input string tag, output int n);
      n = 0;
      while (32'(sel ? state_b : state_a) !== s && n < lim) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(sel ? state_b : state_a), s);
   endtask

   task automatic wait_tick_a(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (tk_a !== 1'b1 && n < 400);
      chk("a_tick_seen", 32'(tk_a), 32'd1);
   endtask

   // Counts gate/tick cycles over one period; retarget=1 changes cmd mid-period
   task automatic count_win_a(input bit retarget, output int h, output int l, output int t);
      h = 0; l = 0; t = 0;
      for (int i = 0; i < 255; i++) begin
         @(negedge clk);
         if (hi_a === 1'b1) h++;
         if (lo_a === 1'b1) l++;
         if (tk_a === 1'b1) t++;
         if (retarget && i == 59) cmd_a = 8'd200;
         if (retarget && i == 60) chk("a_retarget_ramp", 32'(state_a), RAMP);
      end
   endtask

   int n, h, l, t;

   initial begin
      rst = 1'b1;
      en_a = 1'b0; oh_a = 1'b0; es_a = 1'b0; cmd_a = 8'd0;
      en_b = 1'b0; oh_b = 1'b0; es_b = 1'b0; cmd_b = 8'd0;
      repeat (3) @(negedge clk);
      chk("rst_hi", 32'(hi_a), 32'd0);
      chk("rst_lo", 32'(lo_a), 32'd0);
      chk("rst_duty", 32'(duty_a), 32'd0);
      chk("rst_state", 32'(state_a), OFF);
      chk("rst_at_speed", 32'(at_a), 32'd0);
      chk("rst_tick", 32'(tk_a), 32'd0);
      chk("rst_b_state", 32'(state_b), OFF);
      chk("rst_b_duty", 32'(duty_b), 32'd0);
      rst = 1'b0;
      mon_en = 1'b1;

      // Ramp 0 -> 128 at defaults: 128 ticks of 16 cycles
      for (int v = 1; v <= 128; v++) exp_a.push_back(8'(v));
      cmd_a = 8'd128;
      en_a  = 1'b1;
      @(negedge clk);
      chk("a_off_to_ramp", 32'(state_a), RAMP);
      chk("a_ramp_at_speed", 32'(at_a), 32'd0);
      n = 1;
      while (32'(state_a) !== RUN && n < 2200) begin
         @(negedge clk);
         n++;
      end
      chk("a_ramp128_cycles", 32'(n), 32'd2048);
      chk("a_run_duty", 32'(duty_a), 32'd128);
      chk("a_run_at_speed", 32'(at_a), 32'd1);

      // Gate waveform at duty 128: 124 high, 123 low (incl. carried cycle), one tick
      wait_tick_a(n);
      wait_tick_a(n);
      chk("a_period_len", 32'(n), 32'd255);
      count_win_a(1'b0, h, l, t);
      chk("a_hi_128", 32'(h), 32'd124);
      chk("a_lo_128", 32'(l), 32'd123);
      chk("a_ticks_per_period", 32'(t), 32'd1);

      // Mid-period retarget: gates keep the latched duty until the boundary
      for (int v = 129; v <= 200; v++) exp_a.push_back(8'(v));
      count_win_a(1'b1, h, l, t);
      chk("a_hi_latched", 32'(h), 32'd124);
      chk("a_lo_latched", 32'(l), 32'd123);
      wait_state(1'b0, RUN, 1300, "a_run_200", n);
      chk("a_duty_200", 32'(duty_a), 32'd200);

      // Overheat derates to 100, clearing it ramps back to 200
      for (int v = 199; v >= 100; v--) exp_a.push_back(8'(v));
      oh_a = 1'b1;
      @(negedge clk);
      chk("a_oh_ramp", 32'(state_a), RAMP);
      chk("a_oh_at_speed", 32'(at_a), 32'd0);
      wait_state(1'b0, RUN, 1700, "a_oh_run", n);
      chk("a_oh_duty", 32'(duty_a), 32'd100);
      for (int v = 101; v <= 200; v++) exp_a.push_back(8'(v));
      oh_a = 1'b0;
      @(negedge clk);
      chk("a_oh_clear_ramp", 32'(state_a), RAMP);
      wait_state(1'b0, RUN, 1700, "a_oh_clear_run", n);
      chk("a_oh_clear_duty", 32'(duty_a), 32'd200);

      // Back to 128, then an estop pulse
      for (int v = 199; v >= 128; v--) exp_a.push_back(8'(v));
      cmd_a = 8'd128;
      @(negedge clk);
      wait_state(1'b0, RUN, 1300, "a_run_128b", n);
      exp_a.push_back(8'd0);
      es_a = 1'b1;
      @(negedge clk);
      es_a = 1'b0;
      chk("a_estop_state", 32'(state_a), STOP);
      chk("a_estop_duty", 32'(duty_a), 32'd0);
      chk("a_estop_hi", 32'(hi_a), 32'd0);
      chk("a_estop_lo", 32'(lo_a), 32'd0);
      repeat (5) @(negedge clk);
      chk("a_stop_hold", 32'(state_a), STOP);
      chk("a_stop_hold_lo", 32'(lo_a), 32'd0);
      en_a = 1'b0;
      @(negedge clk);
      chk("a_stop_to_off", 32'(state_a), OFF);
      for (int v = 1; v <= 3; v++) exp_a.push_back(8'(v));
      cmd_a = 8'd3;
      en_a  = 1'b1;
      @(negedge clk);
      chk("a_rearm_ramp", 32'(state_a), RAMP);
      wait_state(1'b0, RUN, 100, "a_rearm_run", n);
      chk("a_rearm_duty", 32'(duty_a), 32'd3);

      // Duty 2 is shorter than the dead time: high side never fires
      exp_a.push_back(8'd2);
      cmd_a = 8'd2;
      n = 0;
      while (!(32'(state_a) === RUN && duty_a === 8'd2) && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("a_duty_2", 32'(duty_a), 32'd2);
      wait_tick_a(n);
      wait_tick_a(n);
      count_win_a(1'b0, h, l, t);
      chk("a_hi_duty2", 32'(h), 32'd0);
      chk("a_lo_duty2", 32'(l), 32'd249);

      // Disable: ramp down to zero and coast in OFF
      exp_a.push_back(8'd1);
      exp_a.push_back(8'd0);
      en_a = 1'b0;
      wait_state(1'b0, OFF, 100, "a_disable_off", n);
      @(negedge clk);
      chk("a_off_duty", 32'(duty_a), 32'd0);
      chk("a_off_hi", 32'(hi_a), 32'd0);
      chk("a_off_lo", 32'(lo_a), 32'd0);

      // Coarse step: 100, 200, 255 up and 155, 55, 0 down without wrap
      exp_b.push_back(8'd100); exp_b.push_back(8'd200); exp_b.push_back(8'd255);
      cmd_b = 8'd255;
      en_b  = 1'b1;
      wait_state(1'b1, RUN, 30, "b_run_255", n);
      chk("b_duty_255", 32'(duty_b), 32'd255);
      chk("b_at_speed", 32'(at_b), 32'd1);
      exp_b.push_back(8'd155); exp_b.push_back(8'd55); exp_b.push_back(8'd0);
      cmd_b = 8'd0;
      @(negedge clk);
      chk("b_down_ramp", 32'(state_b), RAMP);
      wait_state(1'b1, OFF, 30, "b_down_off", n);
      chk("b_down_duty", 32'(duty_b), 32'd0);

      // Mid-operation reset behaves like power-up
      exp_b.push_back(8'd100); exp_b.push_back(8'd200);
      cmd_b = 8'd255;
      n = 0;
      while (duty_b !== 8'd200 && n < 30) begin
         @(negedge clk);
         n++;
      end
      chk("b_pre_reset_duty", 32'(duty_b), 32'd200);
      exp_b.push_back(8'd0);
      rst = 1'b1;
      @(negedge clk);
      rst   = 1'b0;
      en_b  = 1'b0;
      cmd_b = 8'd0;
      chk("b_rst_state", 32'(state_b), OFF);
      chk("b_rst_duty", 32'(duty_b), 32'd0);
      chk("b_rst_hi", 32'(hi_b), 32'd0);
      chk("b_rst_lo", 32'(lo_b), 32'd0);
      chk("b_rst_at_speed", 32'(at_b), 32'd0);
      chk("b_rst_tick", 32'(tk_b), 32'd0);
      repeat (3) @(negedge clk);

      chk("a_queue_drained", 32'(exp_a.size()), 32'd0);
      chk("b_queue_drained", 32'(exp_b.size()), 32'd0);
      chk("no_gate_overlap", 32'(overlaps), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
